// File: rtl/cv32e40p_tmr_vote_monitor_pkg.sv
// Shared types and helpers for the TMR voting monitor: FSM states, replica index and index/one-hot conversion.
package cv32e40p_tmr_pkg;

    localparam int NREP = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } tmr_state_e;

    typedef logic [1:0] tmr_replica_t;

    function automatic tmr_replica_t lowest_idx(input logic [NREP-1:0] v);
        tmr_replica_t r;
        if (v[0]) begin
            r = 2'd0;
        end else if (v[1]) begin
            r = 2'd1;
        end else begin
            r = 2'd2;
        end
        return r;
    endfunction

    function automatic logic [NREP-1:0] rep_onehot(input tmr_replica_t r);
        logic [NREP-1:0] oh;
        case (r)
            2'd0:    oh = 3'b001;
            2'd1:    oh = 3'b010;
            2'd2:    oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/cv32e40p_tmr_vote_monitor_if.sv
// Replica data, voted result and recovery/status signals of the TMR voting monitor.
interface cv32e40p_tmr_vote_monitor_if
    import cv32e40p_tmr_pkg::*;
#(
    parameter int NBIT  = 32,
    parameter int NCH   = 5,
    parameter int CNT_W = 8
);
    logic [NCH*NBIT-1:0] data_a_i;
    logic [NCH*NBIT-1:0] data_b_i;
    logic [NCH*NBIT-1:0] data_c_i;
    logic [NCH*NBIT-1:0] data_o;
    logic [NCH-1:0]      error_ch_o;
    logic                no_majority_o;
    logic [NREP-1:0]     mask_o;
    logic [NREP-1:0]     resync_req_o;
    logic [NREP-1:0]     resync_ack_i;
    logic [NREP-1:0]     fault_sticky_o;
    logic                fatal_o;
    logic [CNT_W-1:0]    resync_cnt_o;
    logic                clear_i;

    modport master (
        output data_a_i, data_b_i, data_c_i, resync_ack_i, clear_i,
        input  data_o, error_ch_o, no_majority_o, mask_o, resync_req_o,
               fault_sticky_o, fatal_o, resync_cnt_o
    );

    modport slave (
        input  data_a_i, data_b_i, data_c_i, resync_ack_i, clear_i,
        output data_o, error_ch_o, no_majority_o, mask_o, resync_req_o,
               fault_sticky_o, fatal_o, resync_cnt_o
    );

endinterface

// File: rtl/cv32e40p_tmr_vote_monitor_replica_mon.sv
// Per-replica disagreement detector with a saturating persistence counter; pulses hit on the
// cycle the counter reaches PERSIST.
module cv32e40p_tmr_replica_mon
    import cv32e40p_tmr_pkg::*;
#(
    parameter int NBIT    = 32,
    parameter int NCH     = 5,
    parameter int PERSIST = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NCH*NBIT-1:0] replica,
    input  logic [NCH*NBIT-1:0] voted,
    input  logic                masked,
    output logic                hit
);
    localparam int CW = $clog2(PERSIST + 1);

    logic [CW-1:0] cnt_r;
    logic          mismatch_s;

    assign mismatch_s = !masked && (replica != voted);
    assign hit        = mismatch_s && (cnt_r == CW'(PERSIST - 1));

    // persistence counter: counts consecutive mismatches, zero on match or while masked
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (masked) begin
            cnt_r <= '0;
        end else if (mismatch_s) begin
            if (cnt_r != CW'(PERSIST)) begin
                cnt_r <= cnt_r + CW'(1);
            end
        end else begin
            cnt_r <= '0;
        end
    end

endmodule

// File: rtl/cv32e40p_tmr_vote_monitor.sv
// TMR voting monitor: majority/masked voter, persistence tracking per replica and a
// single-target resync FSM with sticky fault/fatal status and a completed-resync counter.
module cv32e40p_tmr_vote_monitor
    import cv32e40p_tmr_pkg::*;
#(
    parameter int NBIT     = 32,
    parameter int NCH      = 5,
    parameter int PERSIST  = 3,
    parameter int HOLD_CYC = 4,
    parameter int CNT_W    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    cv32e40p_tmr_vote_monitor_if.slave bus
);
    localparam int W  = NCH * NBIT;
    localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    logic [W-1:0]     a_s, b_s, c_s, vote_s;
    logic [NCH-1:0]   err_s;
    logic             nomaj_s;
    logic [NREP-1:0]  hit_s;
    logic             ack_tgt_s;
    logic             fault_evt_s, done_evt_s, fatal_evt_s;

    tmr_state_e       state_r, state_nx;
    tmr_replica_t     tgt_r, tgt_nx;
    logic [HW-1:0]    hold_r, hold_nx;
    logic [NREP-1:0]  mask_r, req_r, sticky_r;
    logic             fatal_r;
    logic [CNT_W-1:0] rcnt_r;

    assign a_s = bus.data_a_i;
    assign b_s = bus.data_b_i;
    assign c_s = bus.data_c_i;

    // voter: bitwise majority when all replicas are active, else lowest-index active replica
    always_comb begin
        vote_s  = '0;
        nomaj_s = 1'b0;
        case (mask_r)
            3'b000: vote_s = (a_s & b_s) | (a_s & c_s) | (b_s & c_s);
            3'b001: begin vote_s = b_s; nomaj_s = (b_s != c_s); end
            3'b010: begin vote_s = a_s; nomaj_s = (a_s != c_s); end
            3'b100: begin vote_s = a_s; nomaj_s = (a_s != b_s); end
            default: begin vote_s = a_s; nomaj_s = 1'b1; end
        endcase
    end

    // per-channel disagreement among all three replicas, regardless of masking
    always_comb begin
        err_s = '0;
        for (int n = 0; n < NCH; n++) begin
            err_s[n] = (a_s[n*NBIT +: NBIT] != b_s[n*NBIT +: NBIT]) ||
                       (a_s[n*NBIT +: NBIT] != c_s[n*NBIT +: NBIT]) ||
                       (b_s[n*NBIT +: NBIT] != c_s[n*NBIT +: NBIT]);
        end
    end

    for (genvar k = 0; k < NREP; k++) begin : gen_mon
        logic [W-1:0] rep_s;
        assign rep_s = (k == 0) ? a_s : ((k == 1) ? b_s : c_s);
        cv32e40p_tmr_replica_mon #(
            .NBIT    (NBIT),
            .NCH     (NCH),
            .PERSIST (PERSIST)
        ) u_mon (
            .clk     (clk),
            .rst     (rst),
            .replica (rep_s),
            .voted   (vote_s),
            .masked  (mask_r[k]),
            .hit     (hit_s[k])
        );
    end

    assign ack_tgt_s = |(bus.resync_ack_i & rep_onehot(tgt_r));

    // recovery FSM next-state; a hit while busy is escalated to fatal instead of queued
    always_comb begin
        state_nx    = state_r;
        tgt_nx      = tgt_r;
        hold_nx     = hold_r;
        fault_evt_s = 1'b0;
        done_evt_s  = 1'b0;
        fatal_evt_s = 1'b0;
        case (state_r)
            IDLE: begin
                hold_nx = '0;
                if (|hit_s) begin
                    state_nx    = REQ;
                    tgt_nx      = lowest_idx(hit_s);
                    fault_evt_s = 1'b1;
                end else begin
                    state_nx = IDLE;
                end
            end
            REQ: begin
                fatal_evt_s = |hit_s;
                if (ack_tgt_s) begin
                    state_nx = HOLD;
                    hold_nx  = '0;
                end else begin
                    state_nx = REQ;
                end
            end
            HOLD: begin
                fatal_evt_s = |hit_s;
                if (hold_r == HW'(HOLD_CYC - 1)) begin
                    state_nx   = IDLE;
                    hold_nx    = '0;
                    done_evt_s = 1'b1;
                end else begin
                    hold_nx = hold_r + HW'(1);
                end
            end
            default: begin
                state_nx = IDLE;
                hold_nx  = '0;
            end
        endcase
    end

    // FSM state, target and hold counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            tgt_r   <= 2'd0;
            hold_r  <= '0;
        end else begin
            state_r <= state_nx;
            tgt_r   <= tgt_nx;
            hold_r  <= hold_nx;
        end
    end

    // mask, request and status registers; clear_i overrides same-cycle set/increment
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_r   <= '0;
            req_r    <= '0;
            sticky_r <= '0;
            fatal_r  <= 1'b0;
            rcnt_r   <= '0;
        end else begin
            if (fault_evt_s) begin
                mask_r <= mask_r | rep_onehot(tgt_nx);
                req_r  <= rep_onehot(tgt_nx);
            end else if (done_evt_s) begin
                mask_r <= mask_r & ~rep_onehot(tgt_r);
            end else if (state_r == REQ && ack_tgt_s) begin
                req_r <= '0;
            end
            if (bus.clear_i) begin
                sticky_r <= '0;
                fatal_r  <= 1'b0;
                rcnt_r   <= '0;
            end else begin
                if (fault_evt_s) sticky_r <= sticky_r | rep_onehot(tgt_nx);
                if (fatal_evt_s) fatal_r <= 1'b1;
                if (done_evt_s && rcnt_r != '1) rcnt_r <= rcnt_r + CNT_W'(1);
            end
        end
    end

    assign bus.data_o         = vote_s;
    assign bus.error_ch_o     = err_s;
    assign bus.no_majority_o  = nomaj_s;
    assign bus.mask_o         = mask_r;
    assign bus.resync_req_o   = req_r;
    assign bus.fault_sticky_o = sticky_r;
    assign bus.fatal_o        = fatal_r;
    assign bus.resync_cnt_o   = rcnt_r;

endmodule
